// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: glitch-filtered sampling of PS2_CLK/PS2_DAT, 11-bit frame decode.
// Define PS2_RX_KEYDEC_EN to add the E0/F0 prefix decoder and key_* outputs.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [1:0] err_code,
    output logic       busy
`ifdef PS2_RX_KEYDEC_EN
    ,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid
`endif
);

    // state  | meaning
    // IDLE   | waiting for a start bit (DAT=0 on a clock fall)
    // DATA   | shifting in the 8 data bits, LSB first
    // PARITY | waiting for the odd-parity bit
    // STOP   | waiting for the stop bit, then judging the frame
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam int FCW = $clog2(FILTER_LEN) + 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]          r_sync1;
    logic [1:0]          r_sync2;
    logic [1:0]          r_filt;
    logic [1:0][FCW-1:0] r_fcnt;
    logic                r_filt_clk_d;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_par;
    logic [TCW-1:0]      r_to_cnt;
    logic [7:0]          r_rx_data;
    logic                r_rx_valid;
    logic                r_rx_err;
    logic [1:0]          r_err_code;

    logic                w_fall;
    logic                w_dat;
    logic                w_timeout;
    logic                w_start;
    logic                w_shift;
    logic                w_par_ld;
    logic                w_done;
    logic                w_tout;

    // Index 0 is the clock line, index 1 the data line.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_sync1      <= 2'b11;
            r_sync2      <= 2'b11;
            r_filt       <= 2'b11;
            r_fcnt       <= '0;
            r_filt_clk_d <= 1'b1;
        end else begin
            r_sync1      <= {PS2_DAT, PS2_CLK};
            r_sync2      <= r_sync1;
            r_filt_clk_d <= r_filt[0];
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FCW'(FILTER_LEN - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FCW'(1);
                end
            end
        end
    end

    assign w_fall    = r_filt_clk_d & ~r_filt[0];
    assign w_dat     = r_filt[1];
    assign w_timeout = (r_state != ST_IDLE) && !w_fall
                       && (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Losing rx_en outranks everything so an abandoned frame never strobes.
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_shift  = 1'b0;
        w_par_ld = 1'b0;
        w_done   = 1'b0;
        w_tout   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_fall && rx_en && !w_dat) begin
                    w_next  = ST_DATA;
                    w_start = 1'b1;
                end
            end
            ST_DATA: begin
                if (!rx_en) begin
                    w_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_next = ST_IDLE;
                    w_tout = 1'b1;
                end else if (w_fall) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_next = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (!rx_en) begin
                    w_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_next = ST_IDLE;
                    w_tout = 1'b1;
                end else if (w_fall) begin
                    w_par_ld = 1'b1;
                    w_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!rx_en) begin
                    w_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_next = ST_IDLE;
                    w_tout = 1'b1;
                end else if (w_fall) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (w_start) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift) begin
                r_shift <= {w_dat, r_shift[7:1]};
            end
            if (w_par_ld) begin
                r_par <= w_dat;
            end
            if ((r_state == ST_IDLE) || w_fall) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TCW'(1);
            end
        end
    end

    // A bad stop bit is reported as framing even when parity also fails.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            if (w_done) begin
                if (w_dat && ((^r_shift) ^ r_par)) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                    r_err_code <= 2'b00;
                end else begin
                    r_rx_err   <= 1'b1;
                    r_err_code <= w_dat ? 2'b01 : 2'b10;
                end
            end else if (w_tout) begin
                r_rx_err   <= 1'b1;
                r_err_code <= 2'b11;
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_err   = r_rx_err;
    assign err_code = r_err_code;
    assign busy     = (r_state != ST_IDLE);

`ifdef PS2_RX_KEYDEC_EN
    logic       r_ext;
    logic       r_brk;
    logic [7:0] r_key_code;
    logic       r_key_break;
    logic       r_key_ext;
    logic       r_key_valid;

    // Runs off the registered strobe, so key_valid trails rx_valid by one cycle.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_key_code  <= '0;
            r_key_break <= 1'b0;
            r_key_ext   <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_rx_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_rx_valid) begin
                if (r_rx_data == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_rx_data == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_key_code  <= r_rx_data;
                    r_key_break <= r_brk;
                    r_key_ext   <= r_ext;
                    r_key_valid <= 1'b1;
                    r_ext       <= 1'b0;
                    r_brk       <= 1'b0;
                end
            end
        end
    end

    assign key_code  = r_key_code;
    assign key_break = r_key_break;
    assign key_ext   = r_key_ext;
    assign key_valid = r_key_valid;
`endif

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 device-to-host receiver: deserialises 11-bit frames clocked by the keyboard (start, 8 data LSB first, odd parity, stop).
- Presents each byte to the core as a one-cycle strobe with error flags.
- Sits beside the host-to-device transmitter on the same PS2_CLK/PS2_DAT pair and samples the pins only; it never drives them.
- Runs entirely in the CLOCK_50 domain. PS/2 lines are treated as asynchronous inputs.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered line changes (glitch filter).
- TIMEOUT_CYCLES, 100000: CLOCK_50 cycles (2 ms) without a filtered PS2_CLK falling edge mid-frame before the frame is aborted.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- PS2_CLK  input  1  PS/2 clock line, sampled only.
- PS2_DAT  input  1  PS/2 data line, sampled only.
- rx_en  input  1  receive enable; low while the transmitter owns the bus.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle strobe: rx_data is updated and the frame was good.
- rx_err  output  1  one-cycle strobe: the frame was rejected.
- err_code  output  2  reason for rx_err: 01 parity, 10 framing (stop=0), 11 timeout; held until the next strobe.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous): rx_data=0x00, rx_valid=0, rx_err=0, err_code=00, busy=0, FSM=IDLE, filtered lines=1, timeout counter=0.
- Input path:
  - 2-FF synchroniser on each line.
  - Per-line saturating filter counter, width clog2(FILTER_LEN)+1. The filtered value flips only after FILTER_LEN consecutive samples differ from it.
  - A falling edge is filtered CLK going 1->0; it is a one-cycle internal pulse.
  - All bits are sampled on the filtered DAT in the same cycle as the falling-edge pulse.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a fall with rx_en=1 and DAT=0, go to DATA and clear bit_cnt. A fall with DAT=1 is ignored (stays IDLE).
  - DATA: each fall shifts DAT into shift_reg[7] and shifts right, so the first bit ends in [0]. bit_cnt increments 0..7; on the fall with bit_cnt=7, go to PARITY.
  - PARITY: on a fall, latch par_bit and go to STOP.
  - STOP: on a fall, evaluate the frame and return to IDLE.
    - Good frame (DAT=1 and ^shift_reg ^ par_bit == 1): rx_data <= shift_reg and rx_valid=1 for exactly one cycle.
    - Otherwise rx_err=1 for one cycle and rx_data is unchanged.
    - If both parity and framing fail, report framing (10).
- Latency: rx_valid/rx_err assert on the cycle after the 11th fall pulse. Total delay from the pin edge is 2 + FILTER_LEN + 1 cycles.
- Timeout:
  - The counter runs in any non-IDLE state and clears on every fall.
  - On reaching TIMEOUT_CYCLES-1: rx_err=1, err_code=11, FSM=IDLE.
  - The counter is held at 0 in IDLE.
- rx_en falling mid-frame: the frame is abandoned immediately (FSM=IDLE) with no strobe. In IDLE with rx_en=0, falls are ignored.
- rx_valid and rx_err are never high in the same cycle. Neither is high while reset is asserted.
- Back-to-back frames: a start bit on the fall immediately after a stop is accepted with no dead time.

Optional Feature:
- Macro PS2_RX_KEYDEC_EN.
- With the macro defined, extra outputs are added:
  - key_code[7:0], key_break, key_ext, key_valid (one-cycle strobe).
- Prefix handling:
  - A good byte 0xE0 sets the ext flag; 0xF0 sets the brk flag. Neither prefix pulses key_valid.
  - Any other good byte pulses key_valid one cycle after rx_valid, with key_code=byte, key_break=brk, key_ext=ext. Both flags then clear.
  - Flags also clear on rx_err and on reset.
- Without the macro: these ports and the logic do not exist. rx_* behaviour is identical either way.

Test Plan:
- Frame 0x1C with parity=0, stop=1, rx_en=1, 12.5 kHz PS/2 clock -> one rx_valid pulse, rx_data=0x1C, rx_err never high.
- Frame 0x1C with parity=1 -> rx_err pulse, err_code=01, rx_data keeps its previous value, no rx_valid.
- Frame 0x5A with parity=1 and stop=0 -> rx_err, err_code=10. Then frame 0x5A with stop=1 -> rx_valid, rx_data=0x5A.
- Stop PS2_CLK after 5 data bits and wait 100000 cycles -> rx_err, err_code=11, busy=0. The following 0x29 frame is received correctly.
- Assert reset mid-frame after 4 bits, then release -> all outputs at reset values and no strobe. Next full frame 0x1C -> rx_data=0x1C.
- With PS2_RX_KEYDEC_EN, send E0, F0, 0x75 -> exactly one key_valid, key_code=0x75, key_break=1, key_ext=1. A following 0x75 alone gives key_break=0, key_ext=0.
